// File: rtl/modulo_input.sv
// modulo_input: debounced push-button capture of the board switches for the IN instruction.
// Optional macro INPUT_SIGN_EXT_EN sign-extends the captured value instead of zero-extending it.
module modulo_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DATA_W          = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_in,
  input  logic              switch_enable,
  input  logic [DATA_W-1:0] switches,
  input  logic              button_n,
  output logic [31:0]       valor_entrada,
  output logic              input_ready,
  output logic              cpu_wait
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned EXT_W = 32 - DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, DONE} state_t;

  state_t           state;
  state_t           state_next_c;
  logic             capture_c;
  logic [31:0]      capture_value_c;

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             press_evt;
  logic             release_evt;

  // Two-flop synchroniser for the asynchronous key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= button_n;
      sync2 <= sync1;
    end
  end

  // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable      <= 1'b1;
      cnt         <= '0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
    end else begin
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      if (sync2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable      <= sync2;
          cnt         <= '0;
          press_evt   <= ~sync2;
          release_evt <= sync2;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

`ifdef INPUT_SIGN_EXT_EN
  assign capture_value_c = {{EXT_W{switches[DATA_W-1]}}, switches};
`else
  assign capture_value_c = {{EXT_W{1'b0}}, switches};
`endif

  // Handshake state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next_c;
    end
  end

  // Next state; a dropped request aborts before any capture in the same cycle
  always_comb begin
    state_next_c = state;
    capture_c    = 1'b0;
    case (state)
      IDLE: begin
        if (enable_in) state_next_c = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!enable_in) begin
          state_next_c = IDLE;
        end else if (press_evt && switch_enable) begin
          capture_c    = 1'b1;
          state_next_c = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!enable_in)       state_next_c = IDLE;
        else if (release_evt) state_next_c = DONE;
      end
      DONE: begin
        if (!enable_in) state_next_c = IDLE;
      end
      default: state_next_c = IDLE;
    endcase
  end

  // Registered outputs: captured value and DONE decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valor_entrada <= '0;
      input_ready   <= 1'b0;
    end else begin
      if (capture_c) valor_entrada <= capture_value_c;
      input_ready <= (state_next_c == DONE);
    end
  end

  // Stall must assert in the same cycle the request rises
  assign cpu_wait = enable_in & (state != DONE);

endmodule

// File: tb/tb_modulo_input.sv
// Bench for modulo_input: directed scenarios with random switch data, checked against a
// cycle model built from history windows and handshake phases.
module tb_modulo_input;

  localparam int unsigned D  = 4;
  localparam int unsigned DW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable_in = 1'b0;
  logic          switch_enable = 1'b0;
  logic [DW-1:0] switches = '0;
  logic          button_n = 1'b1;
  logic [31:0]   valor_entrada;
  logic          input_ready;
  logic          cpu_wait;

  int checks = 0;
  int errors = 0;

  modulo_input #(.DEBOUNCE_CYCLES(D), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .switch_enable(switch_enable),
    .switches(switches), .button_n(button_n), .valor_entrada(valor_entrada),
    .input_ready(input_ready), .cpu_wait(cpu_wait)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ext(input logic [DW-1:0] v);
`ifdef INPUT_SIGN_EXT_EN
    return {{(32-DW){v[DW-1]}}, v};
`else
    return {{(32-DW){1'b0}}, v};
`endif
  endfunction

  // Reference model: the key level is accepted once the last D synchronised samples agree
  bit          m_s1 = 1'b1, m_s2 = 1'b1, m_stable = 1'b1;
  bit          m_press = 1'b0, m_rel = 1'b0;
  bit [D-1:0]  m_hist = '1;
  int          m_phase = 0;  // 0 idle, 1 waiting press, 2 waiting release, 3 done
  logic [31:0] m_val = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_stable = 1'b1; m_hist = '1;
      m_press = 1'b0; m_rel = 1'b0; m_phase = 0; m_val = '0;
    end else begin
      case (m_phase)
        0: if (enable_in) m_phase = 1;
        1: if (!enable_in) m_phase = 0;
           else if (m_press && switch_enable) begin m_val = ext(switches); m_phase = 2; end
        2: if (!enable_in) m_phase = 0; else if (m_rel) m_phase = 3;
        default: if (!enable_in) m_phase = 0;
      endcase
      m_hist  = {m_hist[D-2:0], m_s2};
      m_press = (m_hist == '0) && m_stable;
      m_rel   = (m_hist == '1) && !m_stable;
      if (m_press || m_rel) m_stable = ~m_stable;
      m_s2 = m_s1;
      m_s1 = button_n;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: sample on the falling edge and compare every output with the model
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("valor_model", valor_entrada, m_val);
      check("ready_model", 32'(input_ready), 32'(m_phase == 3));
      check("wait_model", 32'(cpu_wait), 32'(enable_in && (m_phase != 3)));
    end
  endtask

  task automatic finish_handshake();
    button_n = 1'b1;
    tick(8);
    check("ready_done", 32'(input_ready), 32'd1);
    check("wait_done", 32'(cpu_wait), 32'd0);
    enable_in = 1'b0;
    #1 check("ready_hold", 32'(input_ready), 32'd1);
    tick(1);
    check("ready_fall", 32'(input_ready), 32'd0);
    tick(1);
  endtask

  logic [31:0]   prev;
  logic [DW-1:0] sw;

  initial begin
    // Reset values, including the combinational stall during reset
    #2 rst_n = 1'b0;
    #1 check("rst_valor", valor_entrada, 32'd0);
    check("rst_ready", 32'(input_ready), 32'd0);
    check("rst_wait_lo", 32'(cpu_wait), 32'd0);
    enable_in = 1'b1;
    #1 check("rst_wait_hi", 32'(cpu_wait), 32'd1);
    enable_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Basic read: capture exactly D+3 edges after the press
    enable_in = 1'b1; switch_enable = 1'b1; switches = 13'h0155;
    #1 check("wait_rise", 32'(cpu_wait), 32'd1);
    tick(2);
    button_n = 1'b0;
    tick(D + 2);
    check("basic_early", valor_entrada, 32'd0);
    tick(1);
    check("basic_cap", valor_entrada, 32'h0000_0155);
    tick(2);
    finish_handshake();

    // Bounce rejection: 2-cycle toggles never settle, then one clean press
    sw = 13'($urandom) | 13'h0001;
    if (sw == 13'h0155) sw = 13'h0aaa;
    switches = sw; enable_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      button_n = ~button_n;
      tick(2);
      check("bounce_hold", valor_entrada, 32'h0000_0155);
    end
    button_n = 1'b0;
    tick(D + 3);
    check("bounce_cap", valor_entrada, ext(sw));
    finish_handshake();

    // Switch gate: ignored press, then an accepted press
    prev = valor_entrada;
    sw = ~sw; switches = sw; switch_enable = 1'b0; enable_in = 1'b1;
    button_n = 1'b0; tick(8);
    button_n = 1'b1; tick(8);
    check("gate_valor", valor_entrada, prev);
    check("gate_wait", 32'(cpu_wait), 32'd1);
    switch_enable = 1'b1;
    button_n = 1'b0; tick(8);
    check("gate_cap", valor_entrada, ext(sw));
    finish_handshake();

    // Held button before the request is not a press
    prev = valor_entrada;
    sw = 13'($urandom); switches = sw;
    button_n = 1'b0; tick(8);
    enable_in = 1'b1; tick(8);
    check("held_nocap", valor_entrada, prev);
    button_n = 1'b1; tick(8);
    check("held_rel", valor_entrada, prev);
    button_n = 1'b0; tick(8);
    check("held_cap", valor_entrada, ext(sw));
    finish_handshake();

    // Abort in WAIT_RELEASE keeps the value and never raises ready
    sw = 13'($urandom); switches = sw; enable_in = 1'b1;
    tick(1);
    button_n = 1'b0; tick(8);
    enable_in = 1'b0; tick(1);
    button_n = 1'b1; tick(8);
    check("abort_ready", 32'(input_ready), 32'd0);
    check("abort_valor", valor_entrada, ext(sw));

    // Reset mid WAIT_PRESS acts immediately
    enable_in = 1'b1; tick(2);
    button_n = 1'b0; tick(3);
    #2 rst_n = 1'b0;
    #1 check("arst_valor", valor_entrada, 32'd0);
    check("arst_ready", 32'(input_ready), 32'd0);
    check("arst_wait", 32'(cpu_wait), 32'd1);
    @(negedge clk);
    rst_n = 1'b1; enable_in = 1'b0; button_n = 1'b1;
    tick(8);

    // Extension of an all-ones capture
    switches = 13'h1fff; enable_in = 1'b1; switch_enable = 1'b1;
    tick(1);
    button_n = 1'b0; tick(8);
`ifdef INPUT_SIGN_EXT_EN
    check("ext_ones", valor_entrada, 32'hffff_ffff);
`else
    check("ext_ones", valor_entrada, 32'h0000_1fff);
`endif
    finish_handshake();

    // Random transactions with random gate, glitches and hold lengths
    for (int t = 0; t < 8; t++) begin
      switches = 13'($urandom);
      switch_enable = 1'($urandom);
      enable_in = 1'b1;
      tick($urandom_range(1, 3));
      button_n = 1'b0; tick($urandom_range(1, 3));
      button_n = 1'b1; tick(1);
      button_n = 1'b0; tick($urandom_range(3, 9));
      switches = 13'($urandom);
      button_n = 1'b1; tick($urandom_range(3, 9));
      enable_in = 1'($urandom); tick($urandom_range(1, 4));
      enable_in = 1'b0; tick(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/modulo_input.md
# modulo_input

Board-input block for the IN instruction: samples the data switches when the user confirms with a push button and hands the value to the CPU through a four-phase request/ready handshake, stalling the CPU while it waits. The block sits between the board pins (switches, KEY) and the CPU datapath. It is the input counterpart of the LED/7-segment output module.

## Interface

**Parameters**
- `DEBOUNCE_CYCLES`, default 1000000. Consecutive stable `clk` cycles required to accept a button level change (20 ms at 50 MHz). Minimum 2.
- `DATA_W`, default 13. Number of switch bits captured.

**Ports**
- `clk`, input, 1 bit. 50 MHz clock; the only clock.
- `rst_n`, input, 1 bit. Asynchronous, active-low reset.
- `enable_in`, input, 1 bit. CPU request, synchronous to `clk`. Level, held high for the whole IN instruction.
- `switch_enable`, input, 1 bit. SW[13]. Presses are accepted only while it is 1.
- `switches`, input, `DATA_W` bits. Raw data switches SW[DATA_W-1:0].
- `button_n`, input, 1 bit. Raw confirm key, active-low, asynchronous to `clk`, bouncy.
- `valor_entrada`, output, 32 bits. Captured value, extended to 32 bits.
- `input_ready`, output, 1 bit. Handshake acknowledge; high while in DONE.
- `cpu_wait`, output, 1 bit. Stall request to the CPU.

## Operation

**Synchroniser**
- Two-flop synchroniser on `button_n`. Both flops reset to 1.

**Debouncer**
- Holds a registered `stable` level (reset 1) and a counter (reset 0).
- The counter increments each cycle the synchronised value differs from `stable`. It clears whenever they are equal.
- When the counter equals `DEBOUNCE_CYCLES-1` and the values still differ, on that edge: `stable` takes the synchronised value, the counter clears, and a one-cycle `press_evt` (1→0) or `release_evt` (0→1) pulse is registered.

**FSM** (states: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE; reset to IDLE)
- IDLE: when `enable_in`=1, go to WAIT_PRESS.
- WAIT_PRESS:
  - On `press_evt` with `switch_enable`=1: capture `switches` into `valor_entrada` and go to WAIT_RELEASE.
  - `press_evt` with `switch_enable`=0 is ignored.
  - A button already held when the request arrives does not count as a press; a new 1→0 event is required.
- WAIT_RELEASE: on `release_evt`, go to DONE.
- DONE: `input_ready`=1. When `enable_in`=0, go to IDLE.
- Abort: if `enable_in` falls in WAIT_PRESS or WAIT_RELEASE, go to IDLE. `valor_entrada` keeps its last value, whether or not a capture already happened in WAIT_PRESS.

**Outputs**
- `cpu_wait` = `enable_in` & (state ≠ DONE). Combinational, so the stall is asserted in the same cycle the request rises.
- `input_ready` is registered state decode (state == DONE).
- `valor_entrada` changes only on a capture edge.
- Extension: bits [31:DATA_W] = 0, unless the feature in Configuration is compiled in.

## Timing

**Reset values**
- `valor_entrada` = 0, `input_ready` = 0, `cpu_wait` = `enable_in` (state is IDLE), `stable` = 1.

**Latency**
- Raw `button_n` edge held clean → synchroniser output changes 2 edges later.
- → `stable` and the event pulse update `DEBOUNCE_CYCLES` edges after that.
- → FSM acts on the next edge.
- Total: capture `DEBOUNCE_CYCLES`+3 edges after the raw press.

**Handshake timing**
- `release_evt` → DONE on the next edge, so `input_ready` rises 1 cycle after the event cycle. `cpu_wait` falls in the same cycle `input_ready` rises.
- `enable_in` low in DONE → IDLE on the next edge, so `input_ready` falls 1 cycle later.

**Boundary conditions**
- Glitches shorter than `DEBOUNCE_CYCLES` cycles reset the counter and produce no event.
- Back-to-back requests: a new `enable_in` rise is honoured only from IDLE. The minimum gap is one low cycle.
- Asserting `rst_n`=0 in any state returns to the reset values immediately. A capture that was in progress is lost.

## Configuration

- `INPUT_SIGN_EXT_EN`:
  - Defined: `valor_entrada`[31:DATA_W] replicates `switches`[DATA_W-1] at capture, allowing negative operands.
  - Undefined: zero-extended.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4, `DATA_W`=13.

- **Basic read:** reset, `enable_in`=1, `switch_enable`=1, `switches`=0x0155, clean press then release → `cpu_wait`=1 until DONE; `valor_entrada`=0x00000155 exactly 7 edges after the press; `input_ready` high until `enable_in`=0, then low 1 cycle later.
- **Bounce rejection:** `button_n` toggles every 2 cycles for 20 cycles, then held low → exactly one capture, no early event.
- **Switch gate:** `switch_enable`=0, press and release → stays WAIT_PRESS with `cpu_wait`=1 and `valor_entrada` unchanged; set `switch_enable`=1, press again → capture.
- **Held button:** button already held before `enable_in` rises → no capture until release then a new press.
- **Abort and reset:** drop `enable_in` in WAIT_RELEASE → IDLE, `input_ready` never rises; assert `rst_n`=0 mid-WAIT_PRESS → `valor_entrada`=0, state IDLE asynchronously.
- **Configuration:** `switches`=0x1FFF → `valor_entrada`=0xFFFFFFFF with `INPUT_SIGN_EXT_EN` defined, 0x00001FFF without it.
